// File: rtl/pipe_rf_if.sv
// Register file port bundle: two read ports, WB write port, issue port.
// master drives addresses/writes/issues; slave is the register file.
interface pipe_rf_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
);
  logic [ADDR_W-1:0] rs_addr;
  logic [ADDR_W-1:0] rt_addr;
  logic [DATA_W-1:0] rs_data;
  logic [DATA_W-1:0] rt_data;
  logic              rs_busy;
  logic              rt_busy;
  logic              hazard;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              iss_en;
  logic [ADDR_W-1:0] iss_addr;
  logic [ADDR_W:0]   busy_cnt;

  modport master (
    output rs_addr, rt_addr,
    output wr_en, wr_addr, wr_data,
    output iss_en, iss_addr,
    input  rs_data, rt_data,
    input  rs_busy, rt_busy, hazard,
    input  busy_cnt
  );

  modport slave (
    input  rs_addr, rt_addr,
    input  wr_en, wr_addr, wr_data,
    input  iss_en, iss_addr,
    output rs_data, rt_data,
    output rs_busy, rt_busy, hazard,
    output busy_cnt
  );
endinterface

// File: rtl/pipe_rf.sv
// Register file with pending-write scoreboard and two async read ports.
// Define RF_BYPASS_EN to forward same-cycle WB data/busy-clear to reads.
module pipe_rf #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int ZERO_REG = 1
) (
  input  logic      clk,
  input  logic      rst_n,
  pipe_rf_if.slave  rf
);
  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] regs [DEPTH];
  logic [DEPTH-1:0]  busy_q;
  logic [DEPTH-1:0]  busy_d;
  logic [ADDR_W:0]   cnt_q;
  logic [ADDR_W:0]   cnt_d;

  logic wr_ok;
  logic iss_ok;
  logic same_a;
  logic inc;
  logic dec;

  logic rs_zero;
  logic rt_zero;
  logic rs_byp;
  logic rt_byp;
  logic rs_iss;
  logic rt_iss;

  assign rs_zero = (ZERO_REG != 0) && (rf.rs_addr == '0);
  assign rt_zero = (ZERO_REG != 0) && (rf.rt_addr == '0);

  // Writes and issues to a hardwired zero register never take effect.
  assign wr_ok  = rf.wr_en &&
                  !((ZERO_REG != 0) && (rf.wr_addr == '0));
  assign iss_ok = rf.iss_en &&
                  !((ZERO_REG != 0) && (rf.iss_addr == '0));

  assign same_a = (rf.wr_addr == rf.iss_addr);

  assign inc = iss_ok && !busy_q[rf.iss_addr];
  assign dec = wr_ok && busy_q[rf.wr_addr] &&
               !(iss_ok && same_a);

  always_comb begin
    busy_d = busy_q;
    if (wr_ok)
      busy_d[rf.wr_addr] = 1'b0;
    if (iss_ok)
      busy_d[rf.iss_addr] = 1'b1;
  end

  always_comb begin
    cnt_d = cnt_q + (ADDR_W+1)'(inc)
                  - (ADDR_W+1)'(dec);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++)
        regs[i] <= '0;
    end else if (wr_ok) begin
      regs[rf.wr_addr] <= rf.wr_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q <= '0;
      cnt_q  <= '0;
    end else begin
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
    end
  end

  assign rs_iss = iss_ok && (rf.iss_addr == rf.rs_addr);
  assign rt_iss = iss_ok && (rf.iss_addr == rf.rt_addr);

`ifdef RF_BYPASS_EN
  assign rs_byp = wr_ok && (rf.wr_addr == rf.rs_addr);
  assign rt_byp = wr_ok && (rf.wr_addr == rf.rt_addr);
`else
  assign rs_byp = 1'b0;
  assign rt_byp = 1'b0;
`endif

  always_comb begin
    rf.rs_data = regs[rf.rs_addr];
    if (rs_zero)
      rf.rs_data = '0;
    else if (rs_byp)
      rf.rs_data = rf.wr_data;
  end

  always_comb begin
    rf.rt_data = regs[rf.rt_addr];
    if (rt_zero)
      rf.rt_data = '0;
    else if (rt_byp)
      rf.rt_data = rf.wr_data;
  end

  // A forwarded write retires the producer unless a new one issues now.
  assign rf.rs_busy = busy_q[rf.rs_addr] && !rs_zero &&
                      !(rs_byp && !rs_iss);
  assign rf.rt_busy = busy_q[rf.rt_addr] && !rt_zero &&
                      !(rt_byp && !rt_iss);

  assign rf.hazard   = rf.rs_busy | rf.rt_busy;
  assign rf.busy_cnt = cnt_q;

endmodule
